// File: rtl/ws2811_frame_sequencer.sv
// WS2811 frame sequencer: pops pixel bytes from a show-ahead FIFO
// and serialises one frame MSB first, then holds a low latch gap.
//
// Ports:
//   clk, rst_       clock, async active-low reset
//   start           one-cycle frame request, honoured only in IDLE
//   fifo_q          FIFO head byte, valid while fifo_empty=0
//   fifo_empty      FIFO has no data
//   fifo_rdreq      one-cycle pop per consumed byte
//   dout            WS2811 serial line
//   busy            high in every state except IDLE
//   frame_done      pulse at end of the latch gap
//   underrun        pulse when a mid-frame byte is missing
module ws2811_frame_sequencer #(
    parameter int NUM_LEDS  = 50,
    parameter int BIT_CYC   = 16,
    parameter int T0H_CYC   = 4,
    parameter int T1H_CYC   = 12,
    parameter int RESET_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       start,
    input  logic [7:0] fifo_q,
    input  logic       fifo_empty,
    output logic       fifo_rdreq,
    output logic       dout,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam int FRAME_BYTES = 3 * NUM_LEDS;
    localparam int CYC_W  = $clog2(BIT_CYC) + 1;
    localparam int BYTE_W = $clog2(FRAME_BYTES) + 1;
    localparam int LAT_W  = $clog2(RESET_CYC) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(BIT_CYC - 1);
    localparam logic [CYC_W-1:0]  T0H       = CYC_W'(T0H_CYC);
    localparam logic [CYC_W-1:0]  T1H       = CYC_W'(T1H_CYC);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(FRAME_BYTES - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RESET_CYC - 1);

    logic [1:0]        state, state_d;
    logic [CYC_W-1:0]  cyc, cyc_d;
    logic [2:0]        bit_cnt, bit_d;
    logic [BYTE_W-1:0] byte_cnt, byte_d;
    logic [LAT_W-1:0]  lat_cnt, lat_d;
    logic [7:0]        shreg, shreg_d;
    logic              rdreq_d, under_d, done_d;
    logic              dout_d, busy_d;
    logic [CYC_W-1:0]  th_d;

    always_comb begin
        state_d = state;
        cyc_d   = cyc;
        bit_d   = bit_cnt;
        byte_d  = byte_cnt;
        lat_d   = lat_cnt;
        shreg_d = shreg;
        rdreq_d = 1'b0;
        under_d = 1'b0;
        done_d  = 1'b0;
        unique case (1'b1)
            (state == S_IDLE): begin
                if (start) state_d = S_WAIT;
            end
            (state == S_WAIT): begin
                if (!fifo_empty) begin
                    shreg_d = fifo_q;
                    rdreq_d = 1'b1;
                    byte_d  = '0;
                    bit_d   = '0;
                    cyc_d   = '0;
                    state_d = S_SEND;
                end
            end
            (state == S_SEND): begin
                if (cyc == CYC_LAST) begin
                    cyc_d   = '0;
                    shreg_d = {shreg[6:0], 1'b0};
                    bit_d   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        bit_d = '0;
                        if (byte_cnt == BYTE_LAST) begin
                            state_d = S_LATCH;
                            lat_d   = '0;
                        end else if (!fifo_empty) begin
                            // next byte loads on the boundary itself,
                            // so bit cells stay back to back
                            shreg_d = fifo_q;
                            rdreq_d = 1'b1;
                            byte_d  = byte_cnt + 1'b1;
                        end else begin
                            under_d = 1'b1;
                            state_d = S_LATCH;
                            lat_d   = '0;
                        end
                    end
                end else begin
                    cyc_d = cyc + 1'b1;
                end
            end
            (state == S_LATCH): begin
                if (lat_cnt == LAT_LAST) begin
                    done_d  = 1'b1;
                    lat_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    lat_d = lat_cnt + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // outputs are registered from next-state values so the line
        // changes on the same edge as the state that defines it
        th_d   = shreg_d[7] ? T1H : T0H;
        dout_d = (state_d == S_SEND) && (cyc_d < th_d);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state      <= S_IDLE;
            cyc        <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            lat_cnt    <= '0;
            shreg      <= '0;
            fifo_rdreq <= 1'b0;
            dout       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_d;
            cyc        <= cyc_d;
            bit_cnt    <= bit_d;
            byte_cnt   <= byte_d;
            lat_cnt    <= lat_d;
            shreg      <= shreg_d;
            fifo_rdreq <= rdreq_d;
            dout       <= dout_d;
            busy       <= busy_d;
            frame_done <= done_d;
            underrun   <= under_d;
        end
    end

endmodule

// File: tb/tb_ws2811_frame_sequencer.sv
// Bench for ws2811_frame_sequencer: show-ahead FIFO model plus a
// byte-level waveform model of each frame.
module tb_ws2811_frame_sequencer;

    localparam int NL = 1;
    localparam int BC = 16;
    localparam int T0 = 4;
    localparam int T1 = 12;
    localparam int RC = 32;
    localparam int FB = 3 * NL;

    logic       clk = 1'b0;
    logic       rst_;
    logic       start = 1'b0;
    logic [7:0] fifo_q;
    logic       fifo_empty;
    logic       fifo_rdreq, dout, busy, frame_done, underrun;

    always #5 clk = ~clk;

    ws2811_frame_sequencer #(
        .NUM_LEDS (NL),
        .BIT_CYC  (BC),
        .T0H_CYC  (T0),
        .T1H_CYC  (T1),
        .RESET_CYC(RC)
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .start     (start),
        .fifo_q    (fifo_q),
        .fifo_empty(fifo_empty),
        .fifo_rdreq(fifo_rdreq),
        .dout      (dout),
        .busy      (busy),
        .frame_done(frame_done),
        .underrun  (underrun)
    );

    logic [7:0] mem [0:15];
    int  rd = 0;
    int  wr = 0;
    bit  flush = 1'b0;
    int  pops = 0;
    int  rd_empty_err = 0;

    assign fifo_empty = (rd == wr);
    assign fifo_q     = mem[rd[3:0]];

    always @(posedge clk) begin
        if (flush) rd <= wr;
        else if (fifo_rdreq) begin
            pops <= pops + 1;
            if (rd == wr) rd_empty_err <= rd_empty_err + 1;
            else rd <= rd + 1;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [7:0] mq [$];
    logic [7:0] pat [0:7];
    bit   exp_w [$];
    bit   got_w [$];
    int   exp_bytes;
    int   exp_under;

    task automatic push(input logic [7:0] b);
        mem[wr[3:0]] = b;
        wr = wr + 1;
        mq.push_back(b);
    endtask

    // expected line: each byte MSB first, one BC-cycle cell per bit
    // with a T1/T0 high time, then RC low cycles of latch gap
    task automatic build_exp();
        logic [7:0] b;
        int th;
        exp_w.delete();
        exp_bytes = 0;
        while (exp_bytes < FB && mq.size() > 0) begin
            b = mq.pop_front();
            exp_bytes++;
            for (int i = 7; i >= 0; i--) begin
                th = b[i] ? T1 : T0;
                for (int c = 0; c < BC; c++) exp_w.push_back(c < th);
            end
        end
        exp_under = (exp_bytes < FB) ? 1 : 0;
        for (int c = 0; c < RC; c++) exp_w.push_back(1'b0);
    endtask

    task automatic do_frame(input int npush, input int delay,
                            input int inj_a, input int inj_b,
                            input string tag);
        int waited, idx, fd_idx, un_idx, un_cnt, rq_cnt;
        int bad_busy, bad_wait, errs, first_err;
        bit g;
        if (delay == 0) begin
            for (int i = 0; i < npush; i++) push(pat[i]);
            build_exp();
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (delay > 0) begin
            bad_wait = 0;
            for (int k = 0; k < delay; k++) begin
                if (dout !== 1'b0 || busy !== 1'b1) bad_wait++;
                @(negedge clk);
            end
            for (int i = 0; i < npush; i++) push(pat[i]);
            build_exp();
            check({tag, ".wait_idle"}, bad_wait, 0);
        end
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (dout !== 1'b1 && waited < 200);
        check({tag, ".start_lat"}, waited, 1);
        got_w.delete();
        idx = 0;
        fd_idx = -1;
        un_idx = -1;
        un_cnt = 0;
        rq_cnt = 0;
        bad_busy = 0;
        while (idx < 3000) begin
            got_w.push_back(dout);
            if (fifo_rdreq === 1'b1) rq_cnt++;
            if (underrun === 1'b1) begin
                un_cnt++;
                un_idx = idx;
            end
            if (frame_done === 1'b1) begin
                fd_idx = idx;
                break;
            end
            if (busy !== 1'b1) bad_busy++;
            start = (idx == inj_a || idx == inj_b);
            @(negedge clk);
            idx++;
        end
        start = 1'b0;
        check({tag, ".done_at"}, fd_idx, exp_w.size());
        check({tag, ".busy_end"}, busy, 0);
        check({tag, ".busy_run"}, bad_busy, 0);
        check({tag, ".rdreq"}, rq_cnt, exp_bytes);
        check({tag, ".underrun"}, un_cnt, exp_under);
        if (exp_under != 0)
            check({tag, ".under_at"}, un_idx, exp_bytes * 8 * BC);
        errs = 0;
        first_err = -1;
        for (int i = 0; i < exp_w.size(); i++) begin
            g = (i < got_w.size()) ? got_w[i] : 1'b0;
            if (g != exp_w[i]) begin
                errs++;
                if (first_err < 0) first_err = i;
            end
        end
        if (errs != 0) $display("%s first wave diff at %0d", tag, first_err);
        check({tag, ".wave"}, errs, 0);
    endtask

    task automatic idle_tail(input int n, input string tag);
        int bad;
        bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (busy !== 1'b0 || frame_done !== 1'b0 || dout !== 1'b0)
                bad++;
        end
        check({tag, ".idle"}, bad, 0);
    endtask

    int exp_hw [24];
    int hw [$];
    int run;
    int bad;
    int p0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_hw = '{12, 4, 12, 4, 4, 12, 4, 12,
                   4, 4, 4, 4, 4, 4, 4, 4,
                   12, 12, 12, 12, 12, 12, 12, 12};
        rst_ = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.dout", dout, 0);
        check("rst.busy", busy, 0);
        check("rst.rdreq", fifo_rdreq, 0);
        check("rst.done", frame_done, 0);
        check("rst.under", underrun, 0);
        rst_ = 1'b1;
        @(negedge clk);

        pat[0] = 8'hA5;
        pat[1] = 8'h00;
        pat[2] = 8'hFF;
        p0 = pops;
        do_frame(3, 0, -1, -1, "dir");
        hw.delete();
        run = 0;
        foreach (got_w[i]) begin
            if (got_w[i]) run++;
            else if (run > 0) begin
                hw.push_back(run);
                run = 0;
            end
        end
        check("dir.nhigh", hw.size(), 24);
        bad = 0;
        for (int i = 0; i < 24; i++)
            if (i >= hw.size() || hw[i] != exp_hw[i]) bad++;
        check("dir.widths", bad, 0);
        idle_tail(10, "dir");
        check("dir.pops", pops - p0, 3);

        for (int i = 0; i < 3; i++) pat[i] = 8'($urandom);
        do_frame(3, 50, -1, -1, "wait");
        idle_tail(5, "wait");

        for (int i = 0; i < 2; i++) pat[i] = 8'($urandom);
        p0 = pops;
        do_frame(2, 0, -1, -1, "under");
        idle_tail(5, "under");
        check("under.pops", pops - p0, 2);

        for (int i = 0; i < 3; i++) pat[i] = 8'($urandom);
        do_frame(3, 0, 100, 400, "ign1");
        idle_tail(40, "ign1");
        for (int i = 0; i < 3; i++) pat[i] = 8'($urandom);
        do_frame(3, 0, 200, 8 * FB * BC + RC - 1, "ign2");
        idle_tail(40, "ign2");

        for (int i = 0; i < 3; i++) push(8'($urandom));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (150) @(negedge clk);
        #3 rst_ = 1'b0;
        #1;
        check("arst.dout", dout, 0);
        check("arst.busy", busy, 0);
        check("arst.rdreq", fifo_rdreq, 0);
        @(negedge clk);
        flush = 1'b1;
        mq.delete();
        @(negedge clk);
        flush = 1'b0;
        rst_ = 1'b1;
        idle_tail(5, "arst");
        for (int i = 0; i < 3; i++) pat[i] = 8'($urandom);
        do_frame(3, 0, -1, -1, "post_rst");
        idle_tail(5, "post_rst");

        for (int i = 0; i < 6; i++) pat[i] = 8'($urandom);
        p0 = pops;
        do_frame(6, 0, -1, -1, "b2b1");
        do_frame(0, 0, -1, -1, "b2b2");
        idle_tail(5, "b2b");
        check("b2b.pops", pops - p0, 6);

        for (int r = 0; r < 4; r++) begin
            int np, dl;
            np = $urandom_range(1, 3);
            dl = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 20) : 0;
            for (int i = 0; i < np; i++) pat[i] = 8'($urandom);
            do_frame(np, dl, -1, -1, $sformatf("rnd%0d", r));
            idle_tail(3, $sformatf("rnd%0d", r));
        end

        check("fifo.empty_pop", rd_empty_err, 0);
        check("fifo.level", wr - rd, mq.size());

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ws2811_frame_sequencer.md
Name: ws2811_frame_sequencer

Overview:
Single-clock controller that drains pixel bytes from the host-fed show-ahead FIFO and drives the WS2811 strip line. It emits one complete frame of 3*NUM_LEDS bytes, MSB first, then holds the line low for the latch/reset gap. It owns the FIFO read port and replaces the free-running byte/bit clock dividers with counted bit timing on one clock domain.

Parameters:
NUM_LEDS, 50, LEDs per frame; frame length is FRAME_BYTES = 3*NUM_LEDS bytes.
BIT_CYC, 16, clk cycles per bit cell (1.25 us at 12.8 MHz).
T0H_CYC, 4, high cycles for a 0 bit; must be ≥1 and < T1H_CYC.
T1H_CYC, 12, high cycles for a 1 bit; must be < BIT_CYC.
RESET_CYC, 1024, low cycles of the latch gap (>50 us at 12.8 MHz).

Ports:
clk  in  1  system clock; all logic on posedge.
rst_  in  1  asynchronous active-low reset.
start  in  1  one-cycle request to send one frame; ignored while busy=1.
fifo_q  in  8  show-ahead FIFO head byte; valid when fifo_empty=0.
fifo_empty  in  1  FIFO has no data.
fifo_rdreq  out  1  pops the head byte; asserted for one cycle per consumed byte.
dout  out  1  WS2811 serial data line.
busy  out  1  high in every state except IDLE.
frame_done  out  1  one-cycle pulse at the end of the latch gap after a frame.
underrun  out  1  one-cycle pulse when the FIFO is empty at a required byte boundary mid-frame.

Behaviour:
- Reset (rst_=0, any state, takes effect immediately): state=IDLE, dout=0, fifo_rdreq=0, busy=0, frame_done=0, underrun=0, all counters=0. A frame in progress is abandoned and no latch gap is generated.
- All outputs are registered.
- States: IDLE, WAIT_DATA, SEND, LATCH.
- IDLE:
  - On start=1, go to WAIT_DATA.
- WAIT_DATA:
  - Waits indefinitely while fifo_empty=1.
  - When fifo_empty=0: load shreg<=fifo_q, pulse fifo_rdreq, set byte_cnt=0, bit_cnt=0, cyc=0, then go to SEND.
  - dout=0 throughout.
- SEND:
  - cyc counts 0..BIT_CYC-1 within each bit.
  - dout=1 while cyc < (shreg[7] ? T1H_CYC : T0H_CYC), else 0.
  - When cyc=BIT_CYC-1: shift shreg left by 1, increment bit_cnt (0..7), reset cyc to 0.
- Byte boundary (cyc=BIT_CYC-1 and bit_cnt=7):
  - If byte_cnt=FRAME_BYTES-1: go to LATCH.
  - Else if fifo_empty=0: shreg<=fifo_q, fifo_rdreq=1 that same cycle, byte_cnt+1, stay in SEND. This gives zero gap cycles, so bit cells are contiguous.
  - Else: underrun=1 for one cycle, go to LATCH. The strip latches a partial frame.
- First dout high of a frame occurs one cycle after WAIT_DATA samples data; frame length in SEND is exactly FRAME_BYTES*8*BIT_CYC cycles.
- LATCH:
  - dout=0 for RESET_CYC cycles.
  - On the last cycle, frame_done=1 and go to IDLE.
  - frame_done pulses on underrun frames as well.
- start while busy=1 is dropped, not queued.
- start arriving in the same cycle as frame_done's IDLE transition is also dropped: start is honoured only when sampled in IDLE.
- fifo_rdreq is never asserted while fifo_empty=1.
- Exactly one fifo_rdreq per transmitted byte, so a full frame issues FRAME_BYTES pops.
- Counter widths are $clog2 of the respective maximum plus margin; counters never wrap within a frame.

Test Plan:
- Bench parameters NUM_LEDS=1, BIT_CYC=16, T0H=4, T1H=12, RESET_CYC=32. Pre-fill the FIFO with 0xA5,0x00,0xFF and pulse start:
  - dout high widths are 12,4,12,4,4,12,4,12, then 8×4, then 8×12.
  - The 24 bit cells are contiguous.
  - Exactly 3 rdreq pulses.
  - 32 low cycles, then frame_done, then busy=0.
- FIFO empty at start; push a byte after 50 cycles: busy=1, dout=0 while waiting; transmission begins 1 cycle after fifo_empty falls.
- Underrun: only 2 bytes available → after the 16th bit, underrun pulses once, 32-cycle latch, frame_done pulses, only 2 rdreq pulses.
- Pulse start mid-SEND and in the LATCH state: ignored; exactly one frame is sent and exactly one frame_done occurs.
- Assert rst_ low mid-byte (asynchronously, between clock edges): dout, busy and fifo_rdreq go to 0 immediately. After release, a new start sends a full, correct frame.
- Back-to-back frames: start is pulsed the cycle after frame_done. The second frame output is identical in timing, and the total pop count is 6.
